// File: rtl/spart_rx_ctrl.sv
// spart_rx_ctrl: receive-side controller for the SPART serial port.
// Holds the baud divisor, buffers rx_rdy-qualified bytes in a small FIFO,
// tracks overrun and exposes DATA / STATUS / DB_LO / DB_HI to the CPU bus.
// Optional receive interrupt: define SPART_RX_IRQ_EN to enable it.
`timescale 1ns/1ps
module spart_rx_ctrl #(
  parameter int          DEPTH    = 8,
  parameter logic [12:0] BAUD_RST = 13'd434
`ifdef SPART_RX_IRQ_EN
  , parameter int        IRQ_THRESH = 1
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iocs,
  input  logic        iorw,
  input  logic [1:0]  ioaddr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic [12:0] baud,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overrun_reg;
  logic [12:0]   baud_reg;

  logic rd, wr, full, empty;
  logic pop, push, flush, overrun_set, overrun_clr;
  logic wr_db_lo, wr_db_hi, ctrl_wr;
  logic [3:0] count4;
  logic status_bit3;

  assign rd    = iocs & iorw;
  assign wr    = iocs & ~iorw;
  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);

  // A pop on an empty FIFO is a no-op; a pop frees a slot for a same-cycle push.
  assign ctrl_wr     = wr & (ioaddr == 2'd1);
  assign flush       = ctrl_wr & wdata[0];
  assign pop         = rd & (ioaddr == 2'd0) & ~empty;
  assign push        = rx_rdy & ~flush & (~full | pop);
  assign overrun_set = rx_rdy & ~flush & full & ~pop;
  assign overrun_clr = (rd & (ioaddr == 2'd1)) | (ctrl_wr & wdata[1]);
  assign wr_db_lo    = wr & (ioaddr == 2'd2);
  assign wr_db_hi    = wr & (ioaddr == 2'd3);

  assign count4 = 4'(count_reg);
  assign baud   = baud_reg;

  // FIFO pointers/count, overrun flag and baud divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
      baud_reg    <= BAUD_RST;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push && !pop)      count_reg <= count_reg + 1'b1;
        else if (pop && !push) count_reg <= count_reg - 1'b1;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (overrun_set)      overrun_reg <= 1'b1;
      else if (overrun_clr) overrun_reg <= 1'b0;
      if (wr_db_lo) baud_reg[7:0]  <= wdata;
      if (wr_db_hi) baud_reg[12:8] <= wdata[4:0];
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= rx_data;
  end

  // CPU read mux, combinational from the address and current state.
  always_comb begin
    rdata = 8'h00;
    case (ioaddr)
      2'd0: rdata = empty ? 8'h00 : mem[rd_ptr_reg];
      2'd1: rdata = {count4, status_bit3, overrun_reg, full, ~empty};
      2'd2: rdata = baud_reg[7:0];
      default: rdata = {3'b000, baud_reg[12:8]};
    endcase
  end

`ifdef SPART_RX_IRQ_EN
  typedef enum logic {ST_QUIET = 1'b0, ST_ASSERT = 1'b1} irq_state_t;
  localparam logic [AW:0] THRESH = (AW + 1)'(IRQ_THRESH);

  irq_state_t state_reg, state_next;
  logic       irq_en_reg;
  logic       irq_cond;

  assign irq_cond    = irq_en_reg & ((count_reg >= THRESH) | overrun_reg);
  assign status_bit3 = irq_en_reg;
  assign irq         = (state_reg == ST_ASSERT);

  // Interrupt enable bit and interrupt state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_reg <= 1'b0;
      state_reg  <= ST_QUIET;
    end else begin
      if (ctrl_wr) irq_en_reg <= wdata[2];
      state_reg <= state_next;
    end
  end

  // Next-state: follow the interrupt condition with one cycle of lag.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_QUIET:  if (irq_cond)  state_next = ST_ASSERT;
      ST_ASSERT: if (!irq_cond) state_next = ST_QUIET;
      default:   state_next = ST_QUIET;
    endcase
  end
`else
  assign status_bit3 = 1'b0;
  assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx_ctrl.sv
// Scoreboard bench for spart_rx_ctrl: stimulus queues expected values, a
// negedge monitor pops and compares them in the cycle the check is presented.
`timescale 1ns/1ps
module tb_spart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iocs = 1'b0;
  logic        iorw = 1'b0;
  logic [1:0]  ioaddr = 2'd0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic [12:0] baud;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        irq;

  always #5 clk = ~clk;

`ifdef SPART_RX_IRQ_EN
  spart_rx_ctrl #(.DEPTH(8), .BAUD_RST(13'd434), .IRQ_THRESH(2)) dut (
`else
  spart_rx_ctrl #(.DEPTH(8), .BAUD_RST(13'd434)) dut (
`endif
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .wdata(wdata), .rdata(rdata), .baud(baud), .rx_rdy(rx_rdy),
    .rx_data(rx_data), .irq(irq)
  );

  typedef struct {
    string       name;
    int          kind;   // 0 rdata, 1 baud, 2 irq
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  logic chk = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // One bus/receiver cycle; kind >= 0 queues an expected value for this cycle.
  task automatic drive(input logic cs, input logic rw, input logic [1:0] a,
                       input logic [7:0] d, input logic rdy, input logic [7:0] rb,
                       input int kind, input logic [15:0] e, input string nm);
    exp_t t;
    iocs = cs; iorw = rw; ioaddr = a; wdata = d; rx_rdy = rdy; rx_data = rb;
    if (kind >= 0) begin
      t.name = nm; t.kind = kind; t.exp = e;
      sb.push_back(t);
      chk = 1'b1;
    end
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0; rx_rdy = 1'b0; chk = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [7:0] e, input string nm);
    drive(1'b1, 1'b1, a, 8'h00, 1'b0, 8'h00, 0, {8'h00, e}, nm);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    drive(1'b1, 1'b0, a, d, 1'b0, 8'h00, -1, 16'h0, "");
  endtask

  task automatic push(input logic [7:0] b);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, b, -1, 16'h0, "");
  endtask

  task automatic peek(input logic [1:0] a, input logic [7:0] e, input string nm);
    drive(1'b0, 1'b0, a, 8'h00, 1'b0, 8'h00, 0, {8'h00, e}, nm);
  endtask

  task automatic chk_baud(input logic [12:0] e, input string nm);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1, {3'b000, e}, nm);
  endtask

  task automatic chk_irq(input logic e, input string nm);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2, {15'h0, e}, nm);
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectation.
  always @(negedge clk) begin : monitor
    exp_t        t;
    logic [15:0] got;
    if (chk) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got a check request with no expectation");
      end else begin
        t = sb.pop_front();
        case (t.kind)
          0:       got = {8'h00, rdata};
          1:       got = {3'b000, baud};
          default: got = {15'h0, irq};
        endcase
        if (got !== t.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", t.name, got, t.exp);
        end else begin
          $display("ok   %s: %h", t.name, got);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] drain [8];
    drain = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20, 8'h21};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    rd_reg(2'd1, 8'h00, "status_reset");
    chk_baud(13'd434, "baud_reset");
    rd_reg(2'd2, 8'hB2, "db_lo_reset");
    rd_reg(2'd3, 8'h01, "db_hi_reset");
    rd_reg(2'd0, 8'h00, "data_empty_reset");
    chk_irq(1'b0, "irq_reset");

    // Baud divisor writes, upper DB_HI bits ignored
    wr_reg(2'd2, 8'h64);
    chk_baud(13'h0164, "baud_after_lo");
    wr_reg(2'd3, 8'hFA);
    chk_baud(13'h1A64, "baud_after_hi");
    rd_reg(2'd3, 8'h1A, "db_hi_readback");
    rd_reg(2'd2, 8'h64, "db_lo_readback");
    wr_reg(2'd0, 8'hAA);
    peek(2'd1, 8'h00, "status_after_data_write");

    // Basic FIFO order
    push(8'h41); push(8'h42); push(8'h43);
    rd_reg(2'd1, 8'h31, "status_three");
    rd_reg(2'd0, 8'h41, "data_1");
    rd_reg(2'd0, 8'h42, "data_2");
    rd_reg(2'd0, 8'h43, "data_3");
    rd_reg(2'd0, 8'h00, "data_empty");
    rd_reg(2'd1, 8'h00, "status_empty");

    // Push and pop together on an empty FIFO: only the push happens
    drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 8'h55, 0, 16'h0000, "data_empty_with_push");
    peek(2'd1, 8'h11, "status_one_after_empty_pushpop");
    rd_reg(2'd0, 8'h55, "data_pushed_on_empty");

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
    peek(2'd1, 8'h87, "status_full_overrun");
    rd_reg(2'd0, 8'h10, "data_first_after_overrun");
    rd_reg(2'd1, 8'h75, "status_overrun_held");
    rd_reg(2'd1, 8'h71, "status_overrun_cleared");

    // Full with simultaneous pop and push
    push(8'h20);
    peek(2'd1, 8'h83, "status_full");
    drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 8'h21, 0, 16'h0011, "data_pop_push_full");
    peek(2'd1, 8'h83, "status_full_no_overrun");

    // Overrun set and STATUS-read clear in the same cycle: set wins
    drive(1'b1, 1'b1, 2'd1, 8'h00, 1'b1, 8'h22, 0, 16'h0083, "status_read_with_drop");
    peek(2'd1, 8'h87, "overrun_set_wins");
    wr_reg(2'd1, 8'h02);
    peek(2'd1, 8'h83, "ctrl_clear_overrun");
    for (int i = 0; i < 8; i++) rd_reg(2'd0, drain[i], "data_drain");
    peek(2'd1, 8'h00, "status_drained");

    // Flush beats a same-cycle receive
    push(8'h30); push(8'h31);
    drive(1'b1, 1'b0, 2'd1, 8'h01, 1'b1, 8'h32, -1, 16'h0, "");
    peek(2'd1, 8'h00, "status_after_flush");
    rd_reg(2'd0, 8'h00, "data_after_flush");

`ifdef SPART_RX_IRQ_EN
    wr_reg(2'd1, 8'h04);
    peek(2'd1, 8'h08, "status_irq_en");
    push(8'h61);
    chk_irq(1'b0, "irq_one_entry");
    push(8'h62);
    chk_irq(1'b0, "irq_lag");
    chk_irq(1'b1, "irq_assert");
    rd_reg(2'd0, 8'h61, "data_irq_pop");
    chk_irq(1'b1, "irq_hold");
    chk_irq(1'b0, "irq_drop");
    push(8'h70); push(8'h71);
    chk_irq(1'b1, "irq_before_reset");
`else
    push(8'h01); push(8'h02);
    wr_reg(2'd1, 8'h04);
    chk_irq(1'b0, "irq_tied_low");
    peek(2'd1, 8'h21, "status_bit3_ignored");
    push(8'h70); push(8'h71);
`endif

    // Asynchronous reset mid-cycle with a receive in flight
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd1, 8'h00, 1'b1, 8'h72, 0, 16'h0000, "status_during_reset");
    chk_irq(1'b0, "irq_during_reset");
    chk_baud(13'd434, "baud_during_reset");
    rst = 1'b0;
    rd_reg(2'd1, 8'h00, "status_after_reset_release");
    rd_reg(2'd0, 8'h00, "data_after_reset_release");

    @(posedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
